// File: rtl/seq_game_datapath_pkg.sv
// Shared constants for the sequence-memory game datapath: symbol ROM,
// counter width and the hex-to-7-segment decoder.
package seq_game_datapath_pkg;

  localparam int CW = 4;

  typedef logic [CW-1:0] cnt_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [CW-1:0] ROM_TABLE [16] = '{
    4'h3, 4'h7, 4'h1, 4'hC, 4'h5, 4'hA, 4'h0, 4'hE,
    4'h9, 4'h2, 4'hF, 4'h6, 4'hB, 4'h4, 4'h8, 4'hD
  };

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seq_game_datapath_rom.sv
// Fixed 16-entry symbol sequence, read combinationally.
module seq_rom
  import seq_game_datapath_pkg::*;
(
  input  logic [CW-1:0] addr,
  output logic [CW-1:0] data
);

  assign data = ROM_TABLE[addr];

endmodule

// File: rtl/seq_game_datapath.sv
// Game datapath: round/score/playback/entry counters, timeout timer,
// confirm-key capture, and the LED / 7-segment status view.
module seq_game_datapath
  import seq_game_datapath_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TIME_LIMIT = 10,
  parameter int ROUNDS     = 16
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic [7:0] switch,
  input  logic       r1,
  input  logic       r2,
  input  logic       e1,
  input  logic       e2,
  input  logic       e3,
  input  logic       e4,
  input  logic       sel,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [9:0] leds,
  output logic       end_fpga,
  output logic       end_user,
  output logic       end_time,
  output logic       win,
  output logic       match
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam cnt_t           T_LIM      = CW'(TIME_LIMIT);
  localparam cnt_t           R_LAST     = CW'(ROUNDS - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [2:0]    key_sync;
  logic          press;
  cnt_t          cnt_fpga;
  cnt_t          cnt_user;
  cnt_t          time_cnt;
  cnt_t          time_cnt_nxt;
  cnt_t          round_cnt;
  cnt_t          score;
  cnt_t          user_reg;
  cnt_t          sym_fpga;
  cnt_t          sym_user;

  logic unused;
  assign unused = ^{key[3:1], switch[7:4]};

  seq_rom u_rom_fpga (.addr(cnt_fpga), .data(sym_fpga));
  seq_rom u_rom_user (.addr(cnt_user), .data(sym_user));

  assign tick  = (presc == PRESC_LAST);
  assign press = key_sync[2] & ~key_sync[1];

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (r1 || r2 || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // key_sync[1:0] resynchronise the button; key_sync[2] is the previous sample.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      key_sync <= '0;
    end else begin
      key_sync <= {key_sync[1:0], key[0]};
    end
  end

  always_comb begin
    time_cnt_nxt = time_cnt;
    if (e2 && tick && (time_cnt != T_LIM)) begin
      time_cnt_nxt = time_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      cnt_fpga  <= '0;
      cnt_user  <= '0;
      time_cnt  <= '0;
      round_cnt <= '0;
      score     <= '0;
      user_reg  <= '0;
      end_fpga  <= 1'b0;
      end_user  <= 1'b0;
      end_time  <= 1'b0;
      win       <= 1'b0;
      match     <= 1'b0;
    end else if (r1 || r2) begin
      cnt_fpga <= '0;
      cnt_user <= '0;
      time_cnt <= '0;
      end_fpga <= 1'b0;
      end_user <= 1'b0;
      end_time <= 1'b0;
      match    <= 1'b0;
      if (r1) begin
        round_cnt <= '0;
        score     <= '0;
        win       <= 1'b0;
      end
    end else begin
      if (e3 && tick) begin
        if (cnt_fpga == round_cnt) begin
          end_fpga <= 1'b1;
        end else begin
          cnt_fpga <= cnt_fpga + 1'b1;
        end
      end

      time_cnt <= time_cnt_nxt;
      end_time <= (time_cnt_nxt == T_LIM);

      if (e4) begin
        if (!end_user) begin
          if (cnt_user == round_cnt) begin
            end_user <= 1'b1;
          end else begin
            cnt_user <= cnt_user + 1'b1;
            match    <= 1'b0;
          end
        end else begin
          if (score != 4'hF) begin
            score <= score + 1'b1;
          end
          if (round_cnt == R_LAST) begin
            win <= 1'b1;
          end else begin
            round_cnt <= round_cnt + 1'b1;
          end
        end
      end

      // A capture in the same cycle as an advance wins the match update.
      if (e1 && press) begin
        user_reg <= switch[3:0];
        match    <= (switch[3:0] == sym_user);
      end
    end
  end

  always_comb begin
    hex0 = SEG_BLANK;
    if (sel) begin
      hex0 = hex_to_seg(user_reg);
    end else if (e3 && !end_fpga) begin
      hex0 = hex_to_seg(sym_fpga);
    end
  end

  assign hex1 = SEG_BLANK;
  assign hex2 = hex_to_seg(T_LIM - time_cnt);
  assign hex3 = SEG_BLANK;
  assign hex4 = hex_to_seg(round_cnt);
  assign hex5 = hex_to_seg(score);

  always_comb begin
    leds = '0;
    if (sel) begin
      leds[3:0] = user_reg;
    end else if (e3) begin
      leds[3:0] = sym_fpga;
    end
    leds[4] = match;
    leds[9] = end_time;
  end

endmodule

// File: tb/tb_seq_game_datapath.sv
// Bench for seq_game_datapath: directed scenarios with literal expectations,
// then randomized commands, all cross-checked every cycle against a rule model.
module tb_seq_game_datapath;

  localparam int TICK_DIV   = 4;
  localparam int TIME_LIMIT = 3;
  localparam int ROUNDS     = 2;

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] key      = 4'hF;
  logic [7:0] switch   = 8'h00;
  logic       r1 = 1'b0, r2 = 1'b0, e1 = 1'b0, e2 = 1'b0, e3 = 1'b0, e4 = 1'b0, sel = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [9:0] leds;
  logic       end_fpga, end_user, end_time, win, match;

  seq_game_datapath #(
    .TICK_DIV  (TICK_DIV),
    .TIME_LIMIT(TIME_LIMIT),
    .ROUNDS    (ROUNDS)
  ) dut (
    .clock_50(clock_50), .reset(reset), .key(key), .switch(switch),
    .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3), .e4(e4), .sel(sel),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .leds(leds), .end_fpga(end_fpga), .end_user(end_user), .end_time(end_time),
    .win(win), .match(match)
  );

  always #5 clock_50 = ~clock_50;

  logic [3:0] ref_rom [16] = '{4'h3, 4'h7, 4'h1, 4'hC, 4'h5, 4'hA, 4'h0, 4'hE,
                               4'h9, 4'h2, 4'hF, 4'h6, 4'hB, 4'h4, 4'h8, 4'hD};
  logic [6:0] ref_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // Model state: plain integers following the game rules.
  int m_round, m_score, m_win, m_cf, m_cu, m_time, m_presc;
  int m_endf, m_endu, m_endt, m_match, m_user;
  int m_pin [3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_round();
    m_presc = 0; m_cf = 0; m_cu = 0; m_time = 0;
    m_endf = 0; m_endu = 0; m_endt = 0; m_match = 0;
  endtask

  task automatic model_step();
    bit tick, press;
    int cu_old;
    if (reset) begin
      model_clear_round();
      m_round = 0; m_score = 0; m_win = 0; m_user = 0;
      m_pin[0] = 0; m_pin[1] = 0; m_pin[2] = 0;
      return;
    end
    tick  = (m_presc == TICK_DIV - 1);
    // Falling edge of the pin, as seen two and three samples back.
    press = (m_pin[2] == 1) && (m_pin[1] == 0);
    m_pin[2] = m_pin[1];
    m_pin[1] = m_pin[0];
    m_pin[0] = int'(key[0]);
    if (r1 || r2) begin
      if (r1) begin
        m_round = 0; m_score = 0; m_win = 0;
      end
      model_clear_round();
      return;
    end
    m_presc = tick ? 0 : m_presc + 1;
    cu_old  = m_cu;
    if (e3 && tick) begin
      if (m_cf == m_round) m_endf = 1;
      else m_cf++;
    end
    if (e2 && tick && m_time < TIME_LIMIT) m_time++;
    m_endt = (m_time == TIME_LIMIT) ? 1 : 0;
    if (e4) begin
      if (m_endu == 0) begin
        if (m_cu == m_round) m_endu = 1;
        else begin
          m_cu++;
          m_match = 0;
        end
      end else begin
        if (m_score < 15) m_score++;
        if (m_round == ROUNDS - 1) m_win = 1;
        else m_round++;
      end
    end
    if (e1 && press) begin
      m_user  = int'(switch[3:0]);
      m_match = (int'(switch[3:0]) == int'(ref_rom[cu_old])) ? 1 : 0;
    end
  endtask

  initial forever begin
    @(posedge clock_50 or posedge reset);
    model_step();
  end

  task automatic compare_all();
    int exp_hex0, exp_low;
    exp_hex0 = 7'h7F;
    if (sel) exp_hex0 = ref_seg[m_user];
    else if (e3 && m_endf == 0) exp_hex0 = ref_seg[ref_rom[m_cf]];
    exp_low = sel ? m_user : (e3 ? int'(ref_rom[m_cf]) : 0);
    check("hex0", hex0, exp_hex0);
    check("hex1", hex1, 7'h7F);
    check("hex2", hex2, ref_seg[TIME_LIMIT - m_time]);
    check("hex3", hex3, 7'h7F);
    check("hex4", hex4, ref_seg[m_round]);
    check("hex5", hex5, ref_seg[m_score]);
    check("leds", leds, m_endt * 512 + m_match * 16 + exp_low);
    check("end_fpga", end_fpga, m_endf);
    check("end_user", end_user, m_endu);
    check("end_time", end_time, m_endt);
    check("win", win, m_win);
    check("match", match, m_match);
  endtask

  initial forever begin
    @(posedge clock_50);
    #7;
    compare_all();
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_50);
      #2;
    end
  endtask

  task automatic look();
    #5;
  endtask

  task automatic press_key(input logic [3:0] sym);
    switch = {4'h0, sym};
    key[0] = 1'b0;
    cyc(3);
  endtask

  task automatic release_key();
    key[0] = 1'b1;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    look();
    check("rst_end_fpga", end_fpga, 0);
    check("rst_end_user", end_user, 0);
    check("rst_end_time", end_time, 0);
    check("rst_win", win, 0);
    check("rst_match", match, 0);
    check("rst_hex4", hex4, 7'b1000000);
    check("rst_hex0", hex0, 7'h7F);
    check("rst_hex2", hex2, 7'h30);
    check("rst_leds", leds, 0);

    // Playback in round 0: first tick finishes it.
    r2 = 1'b1; e3 = 1'b1;
    cyc(1);
    r2 = 1'b0;
    look();
    check("pb0_hex0_first", hex0, 7'h30);
    cyc(3); look();
    check("pb0_before_tick", end_fpga, 0);
    cyc(1); look();
    check("pb0_after_tick", end_fpga, 1);
    check("pb0_hex0_done", hex0, 7'h7F);
    e3 = 1'b0;

    // Capture: match, mismatch, ignored when e1 low.
    e1 = 1'b1;
    switch = 8'hA3;
    key[0] = 1'b0;
    cyc(2); look();
    check("cap_latency_2", match, 0);
    cyc(1); look();
    check("cap_latency_3", match, 1);
    release_key();
    press_key(4'h5);
    look();
    check("cap_mismatch", match, 0);
    sel = 1'b1;
    #1;
    check("cap_user_hex0", hex0, 7'h12);
    check("cap_user_leds", leds, 10'h005);
    release_key();
    e1 = 1'b0;
    press_key(4'h9);
    look();
    check("cap_ignored", hex0, 7'h12);
    release_key();
    e1 = 1'b1;
    press_key(4'h3);
    look();
    check("cap_match_again", match, 1);
    release_key();
    e1 = 1'b0; sel = 1'b0;

    // Advance round 0.
    e4 = 1'b1; cyc(1); e4 = 1'b0; look();
    check("adv_end_user", end_user, 1);
    e4 = 1'b1; cyc(1); e4 = 1'b0; look();
    check("adv_round", hex4, 7'h79);
    check("adv_score", hex5, 7'h79);
    check("adv_no_win", win, 0);

    // Playback in round 1: '3' then '7', then done on the second tick.
    r2 = 1'b1; e3 = 1'b1;
    cyc(1);
    r2 = 1'b0;
    look();
    check("pb1_hex0_a", hex0, 7'h30);
    check("pb1_end_user_clr", end_user, 0);
    cyc(4); look();
    check("pb1_hex0_b", hex0, 7'h78);
    check("pb1_not_done", end_fpga, 0);
    cyc(4); look();
    check("pb1_done", end_fpga, 1);
    e3 = 1'b0;

    // Timeout timer.
    r2 = 1'b1; e2 = 1'b1;
    cyc(1);
    r2 = 1'b0;
    look();
    check("tmr_hex2_start", hex2, 7'h30);
    cyc(4); look();
    check("tmr_hex2_one", hex2, 7'h24);
    cyc(8); look();
    check("tmr_end_time", end_time, 1);
    check("tmr_led9", int'(leds[9]), 1);
    cyc(4); look();
    check("tmr_saturated", hex2, 7'h40);
    check("tmr_end_hold", end_time, 1);
    r2 = 1'b1; cyc(1); r2 = 1'b0; look();
    check("tmr_r2_clear", end_time, 0);
    check("tmr_r2_hex2", hex2, 7'h30);
    e2 = 1'b0;

    // Final round: step entry counter, finish, then win.
    e4 = 1'b1; cyc(3); e4 = 1'b0; look();
    check("win_set", win, 1);
    check("win_round_hold", hex4, 7'h79);
    check("win_score", hex5, 7'h24);
    r2 = 1'b1; cyc(1); r2 = 1'b0; look();
    check("win_survives_r2", win, 1);
    r1 = 1'b1; cyc(1); r1 = 1'b0; look();
    check("win_r1_clear", win, 0);
    check("r1_round", hex4, 7'h40);
    check("r1_score", hex5, 7'h40);

    // Asynchronous reset mid-playback.
    e3 = 1'b1;
    cyc(5);
    sel = 1'b1;
    look();
    check("ar_pre_end_fpga", end_fpga, 1);
    check("ar_pre_hex0", hex0, 7'h30);
    reset = 1'b1;
    #1;
    check("ar_end_fpga", end_fpga, 0);
    check("ar_hex0", hex0, 7'h40);
    check("ar_leds", leds, 0);
    cyc(2);
    reset = 1'b0; sel = 1'b0; e3 = 1'b0;

    // Randomized commands.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      reset = ($urandom_range(0, 999) == 0);
      r1 = ($urandom_range(0, 299) == 0);
      r2 = ($urandom_range(0, 39) == 0);
      e4 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) e1 = ~e1;
      if ($urandom_range(0, 7) == 0) e2 = ~e2;
      if ($urandom_range(0, 7) == 0) e3 = ~e3;
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      if ($urandom_range(0, 3) == 0) key[0] = ~key[0];
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) switch = {4'($urandom), ref_rom[m_cu % 16]};
        else switch = 8'($urandom);
      end
    end
    reset = 1'b0;
    cyc(2);
    look();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_game_datapath.md
Name: seq_game_datapath

Overview:
- Datapath for the sequence-memory game. It responds to the command set issued by the game FSM (r1, r2, e1–e4, sel) and returns the status set the FSM consumes (end_fpga, end_user, end_time, win, match).
- It holds the round and score counters, the sequence-playback counter, the user-entry counter and the timeout timer. It also drives the board LEDs and the six 7-segment displays.
- It is instantiated beside the FSM in the board top level, one instance per game.

Parameters:
- TICK_DIV, 50_000_000: clock_50 cycles per game tick (1 s on board; small values in simulation).
- TIME_LIMIT, 10: ticks allowed for user entry before end_time asserts (range 1..15).
- ROUNDS, 16: number of rounds; the sequence length of round r is r+1 (range 1..16).

Ports:
- clock_50  in   1  system clock
- reset     in   1  asynchronous, active-high reset
- key       in   4  push-buttons, active-low; key[0] = confirm, key[3:1] unused
- switch    in   8  switch[3:0] = user symbol; switch[7:4] ignored
- r1        in   1  game clear: round, score, win, plus all r2 effects
- r2        in   1  round clear: counters, timer, prescaler, flags
- e1        in   1  enable user entry capture on confirm press
- e2        in   1  enable timeout timer
- e3        in   1  enable sequence playback
- e4        in   1  advance strobe: one-cycle pulse from FSM
- sel       in   1  display select: 0 = playback view, 1 = user view
- hex0..hex5 out 7 each  active-low segments, bit order gfedcba; blank = 7'h7F
- leds      out  10  status LEDs
- end_fpga  out  1  playback of the current round finished
- end_user  out  1  user entered the full sequence for the round
- end_time  out  1  timeout reached
- win       out  1  final round completed
- match     out  1  last captured symbol equals the expected symbol

Behaviour:
- Reset (asynchronous): all counters and registers are 0, all flags are 0.
  - Display at reset: hex0, hex1, hex3 blank; hex2 shows TIME_LIMIT in hex ('A' for the default); hex4 = '0'; hex5 = '0'; leds = 0.
- Tick: the prescaler counts 0..TICK_DIV-1 and produces a one-cycle tick when it wraps. r1 or r2 clears it.
- Priority per cycle is r1 > r2 > e-commands. r1 and r2 act synchronously at the next edge. All commands are evaluated in the same cycle.
- Sequence source: sub-module ROM of 16 entries × 4 bits, addressed combinationally.
- e3 (playback):
  - On tick, if cnt_fpga == round then end_fpga <= 1 (it holds until r1/r2); otherwise cnt_fpga increments.
  - While e3 is high and end_fpga is low, hex0 shows rom[cnt_fpga].
- e1 (capture):
  - key[0] passes through a 2-FF synchronizer; a press is its falling edge (1→0).
  - Press while e1 is high: user_reg <= switch[3:0] and match <= (switch[3:0] == rom[cnt_user]), both at the same edge. Latency is 3 cycles from the pin.
  - A press while e1 is low is ignored.
- e4 (advance):
  - If end_user = 0: when cnt_user == round, end_user <= 1; otherwise cnt_user increments and match <= 0.
  - If end_user = 1: score increments (4-bit, saturating at 15).
    - If round == ROUNDS-1, win <= 1 and round holds.
    - Otherwise round increments.
  - e4 does not clear end_user; the FSM issues r2 for that.
- e2 (timer):
  - On tick, time_cnt increments, saturating at TIME_LIMIT.
  - end_time = (time_cnt == TIME_LIMIT), registered.
- win clears only on reset or r1.
- Reset asserted mid-round returns the block to the reset state immediately. No state survives.
- Displays (combinational from registers):
  - hex2 = TIME_LIMIT - time_cnt.
  - hex4 = round.
  - hex5 = score.
  - hex1 and hex3 blank.
  - sel = 1: hex0 = user_reg.
- LEDs:
  - leds[3:0] = rom[cnt_fpga] when sel = 0 and e3 is high; = user_reg when sel = 1; otherwise 0.
  - leds[4] = match.
  - leds[8:5] = 0.
  - leds[9] = end_time.

Decomposition:
- Package contents:
  - ROM contents: 16 × 4-bit constant, beginning 4'h3, 4'h7, 4'h1, 4'hC, ...
  - SEG_BLANK = 7'h7F.
  - Hex-to-7-segment lookup function.
  - Counter widths: 4 bits.
- One sub-module: seq_rom (combinational address → 4-bit symbol).

Test Plan (TICK_DIV=4, TIME_LIMIT=3):
- Reset then release → all flags 0, hex4 = 7'b1000000 ('0'), hex0 = 7'h7F, hex2 shows '3'.
- r2, then e3 held, round = 0 → end_fpga rises on the first tick, hex0 showed '3' before it; with round = 1 → two ticks, hex0 shows '3' then '7'.
- e1 high, switch = 4'h3, key[0] pulsed low → match = 1 three cycles after the pin edge; switch = 4'h5 → match = 0.
- Round 0 with match = 1: e4 pulse → end_user = 1; a second e4 pulse → round = 1, score = 1.
- e2 held for 3 ticks → end_time = 1 and leds[9] = 1; a further tick leaves time_cnt saturated; r2 clears end_time.
- ROUNDS = 2 and both rounds completed → win = 1 and round stays 1; r2 keeps win = 1; r1 clears win; asynchronous reset asserted mid-playback → immediate return to reset values.
